ifetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of decode/execute.
- Owns the fetch PC and issues 16-bit instruction reads to byte-addressed instruction memory over a request/grant/response handshake.
- Buffers returned instructions, with their PCs, in a small FIFO and presents them to decode with valid/ready.
- Redirects from branch resolution flush the queue and discard in-flight responses.

---
 rtl/ifetch_queue_if.sv | 28 ++
 rtl/ifetch_queue.sv | 164 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response channel,
// decode-side valid/ready instruction channel and branch-redirect inputs.
//   master : the fetch queue (drives requests, instruction head, flush flag)
//   slave  : the environment (memory, decode, branch resolution)
interface ifetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic [15:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        flushing;

    modport master (
        output mem_req, mem_addr, ir_valid, ir, ir_pc, flushing,
        input  mem_gnt, mem_rvalid, mem_rdata, ir_ready, redir, redir_pc
    );

    modport slave (
        input  mem_req, mem_addr, ir_valid, ir, ir_pc, flushing,
        output mem_gnt, mem_rvalid, mem_rdata, ir_ready, redir, redir_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues 16-bit reads to
// instruction memory, buffers returned instructions with their PCs and hands
// them to decode. A redirect reloads the PC, empties the queue and drops the
// responses still in flight.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    ifetch_queue_if.master (memory channel, decode channel, redirect)
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ifetch_queue_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]   tag_rd_q, tag_rd_d;
    logic [TW-1:0]   tag_wr_q, tag_wr_d;

    logic [15:0]     ir_mem  [DEPTH];
    logic [31:0]     pc_mem  [DEPTH];
    logic [31:0]     tag_mem [MAX_OUT];

    logic            mem_req_c;
    logic            gnt;
    logic            rsp;
    logic            push;
    logic            pop;

    function automatic logic [TW-1:0] next_tag(input logic [TW-1:0] ptr);
        return (ptr == TW'(MAX_OUT - 1)) ? '0 : ptr + TW'(1);
    endfunction

    // Issue only when the queue has room for every response already owed.
    assign mem_req_c = !i_rst && (state_q == ST_RUN) && !bus.redir
                     && (outst_q < OW'(MAX_OUT))
                     && ((SW'(count_q) + SW'(outst_q)) < SW'(DEPTH));
    assign gnt  = mem_req_c & bus.mem_gnt;
    // A response with nothing outstanding is stray and ignored.
    assign rsp  = bus.mem_rvalid & (outst_q != '0);
    assign push = rsp & (drop_q == '0) & !bus.redir;
    assign pop  = (count_q != '0) & bus.ir_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Next-state logic: grant/response/pop bookkeeping, redirect overrides
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;

        if (gnt) begin
            fetch_pc_d = fetch_pc_q + 32'd2;
            tag_wr_d   = next_tag(tag_wr_q);
        end
        if (rsp) begin
            tag_rd_d = next_tag(tag_rd_q);
            if (drop_q != '0) begin
                drop_d = drop_q - OW'(1);
            end
        end
        if (gnt && !rsp) begin
            outst_d = outst_q + OW'(1);
        end else if (!gnt && rsp) begin
            outst_d = outst_q - OW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (bus.redir) begin
            // Everything still owed after this cycle belongs to the old path.
            fetch_pc_d = bus.redir_pc & ~32'd1;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_d;
            state_d    = (outst_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   state_d = ST_RUN;
                ST_FLUSH: state_d = (drop_d == '0) ? ST_RUN : ST_FLUSH;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Payload storage; validity is carried by the counters and pointers.
    always_ff @(posedge i_clk) begin
        if (gnt) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            ir_mem[wr_ptr_q] <= bus.mem_rdata;
            pc_mem[wr_ptr_q] <= tag_mem[tag_rd_q];
        end
    end

    assign bus.mem_req  = mem_req_c;
    assign bus.mem_addr = fetch_pc_q;
    assign bus.ir_valid = (count_q != '0);
    assign bus.ir       = (count_q != '0) ? ir_mem[rd_ptr_q] : 16'h0;
    assign bus.ir_pc    = (count_q != '0) ? pc_mem[rd_ptr_q] : 32'h0;
    assign bus.flushing = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios drive a simple in-order memory
// responder and decode; a queue-based reference model predicts every output
// each cycle, and literal expectations pin key addresses, latencies and data.
module tb_ifetch_queue;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_queue_if bus ();

    ifetch_queue #(
        .DEPTH   (4),
        .MAX_OUT (2),
        .RESET_PC(32'h0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus knobs
    bit          gnt_v, ready_v, redir_v, rsp_en, spur, rst_v;
    logic [31:0] redir_pc_v;
    int          lat;

    // memory responder
    logic [31:0] pend_a[$];
    int          pend_due[$];

    // observation logs
    logic [31:0] g_log[$];
    logic [31:0] c_pc[$];
    logic [31:0] c_ir[$];

    // reference model
    logic [31:0] m_pc;
    logic [31:0] m_tags[$];
    int          m_drop;
    logic [15:0] m_fd[$];
    logic [31:0] m_fp[$];
    bit          m_flush;

    // last sampled outputs
    logic        s_req, s_valid, s_flush;
    logic [31:0] s_addr, s_irpc;
    logic [15:0] s_ir;

    int first_g, first_v;

    function automatic logic [7:0] mb(input logic [31:0] x);
        return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [15:0] word(input logic [31:0] a);
        return {mb(a), mb(a + 32'd1)};
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_tags.delete();
        m_drop = 0;
        m_fd.delete();
        m_fp.delete();
        m_flush = 1'b0;
    endtask

    function automatic bit exp_req();
        return !rst && !m_flush && !bus.redir && (m_tags.size() < 2)
               && ((m_fd.size() + m_tags.size()) < 4);
    endfunction

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic model_update();
        bit          g, r, p, keep;
        logic [31:0] tag;
        if (rst) begin
            model_reset();
        end else begin
            g    = exp_req() && bus.mem_gnt;
            r    = bus.mem_rvalid && (m_tags.size() > 0);
            p    = (m_fd.size() > 0) && bus.ir_ready;
            keep = 1'b0;
            tag  = 32'h0;
            if (r) begin
                tag = m_tags.pop_front();
                if (!bus.redir) begin
                    if (m_drop > 0) m_drop--;
                    else            keep = 1'b1;
                end
            end
            if (g) begin
                m_tags.push_back(m_pc);
                m_pc = m_pc + 32'd2;
            end
            if (p) begin
                void'(m_fd.pop_front());
                void'(m_fp.pop_front());
            end
            if (keep) begin
                m_fd.push_back(bus.mem_rdata);
                m_fp.push_back(tag);
            end
            if (bus.redir) begin
                m_pc = bus.redir_pc & ~32'd1;
                m_fd.delete();
                m_fp.delete();
                m_drop  = m_tags.size();
                m_flush = (m_drop > 0);
            end else if (m_flush && m_drop == 0) begin
                m_flush = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive at negedge, compare mid-low-phase, update at posedge.
    task automatic step();
        bit drove;
        @(negedge clk);
        cyc++;
        rst          = rst_v;
        if (rst) begin
            model_reset();
            pend_a.delete();
            pend_due.delete();
        end
        bus.mem_gnt  = gnt_v;
        bus.ir_ready = ready_v;
        bus.redir    = redir_v;
        bus.redir_pc = redir_pc_v;
        drove = 1'b0;
        if (rsp_en && pend_a.size() > 0 && pend_due[0] <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = word(pend_a[0]);
            drove = 1'b1;
        end else if (spur) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 16'hDEAD;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 16'h0;
        end
        #2;
        s_req   = bus.mem_req;
        s_addr  = bus.mem_addr;
        s_valid = bus.ir_valid;
        s_ir    = bus.ir;
        s_irpc  = bus.ir_pc;
        s_flush = bus.flushing;
        chk("mem_req",  32'(s_req),   32'(exp_req()));
        chk("mem_addr", s_addr,       m_pc);
        chk("ir_valid", 32'(s_valid), 32'(m_fd.size() > 0));
        chk("ir",       32'(s_ir),    (m_fd.size() > 0) ? 32'(m_fd[0]) : 32'h0);
        chk("ir_pc",    s_irpc,       (m_fp.size() > 0) ? m_fp[0] : 32'h0);
        chk("flushing", 32'(s_flush), 32'(m_flush));
        if (s_req && bus.mem_gnt) begin
            pend_a.push_back(s_addr);
            pend_due.push_back(cyc + lat);
            g_log.push_back(s_addr);
        end
        if (s_valid && bus.ir_ready) begin
            c_pc.push_back(s_irpc);
            c_ir.push_back(32'(s_ir));
        end
        @(posedge clk);
        model_update();
        if (drove) begin
            void'(pend_a.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic clear_logs();
        g_log.delete();
        c_pc.delete();
        c_ir.delete();
    endtask

    task automatic do_reset();
        rst_v = 1'b1; gnt_v = 1'b0; ready_v = 1'b0; redir_v = 1'b0;
        rsp_en = 1'b0; spur = 1'b0; lat = 1; redir_pc_v = 32'h0;
        repeat (2) step();
        rst_v = 1'b0;
        clear_logs();
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst   = 1'b1;
        rst_v = 1'b1;
        #1;
        chk("arst_req",   32'(bus.mem_req),  32'h0);
        chk("arst_addr",  bus.mem_addr,      32'h0);
        chk("arst_valid", 32'(bus.ir_valid), 32'h0);
        chk("arst_ir",    32'(bus.ir),       32'h0);
        chk("arst_irpc",  bus.ir_pc,         32'h0);
        chk("arst_flush", 32'(bus.flushing), 32'h0);
        model_reset();
        pend_a.delete();
        pend_due.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 16'h0;
        bus.ir_ready = 1'b0; bus.redir = 1'b0; bus.redir_pc = 32'h0;
        model_reset();

        // reset state
        do_reset();
        chk("rst_req",   32'(s_req),   32'h0);
        chk("rst_addr",  s_addr,       32'h0);
        chk("rst_valid", 32'(s_valid), 32'h0);
        chk("rst_ir",    32'(s_ir),    32'h0);
        chk("rst_irpc",  s_irpc,       32'h0);
        chk("rst_flush", 32'(s_flush), 32'h0);

        // streaming: grant every cycle, response one cycle later, decode ready
        gnt_v = 1'b1; ready_v = 1'b1; rsp_en = 1'b1; lat = 1;
        first_g = -1; first_v = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (first_g < 0 && g_log.size() > 0) first_g = cyc;
            if (first_v < 0 && s_valid) first_v = cyc;
        end
        for (int i = 0; i < 4; i++) chk("s1_gaddr", qget(g_log, i), 32'(2 * i));
        chk("s1_latency", 32'(first_v - first_g), 32'd2);
        chk("s1_pc0", qget(c_pc, 0), 32'h0);
        chk("s1_pc1", qget(c_pc, 1), 32'h2);
        chk("s1_ir0", qget(c_ir, 0), 32'h3C3D);

        // backpressure: queue fills to DEPTH, then resumes at 8
        do_reset();
        gnt_v = 1'b1; ready_v = 1'b0; rsp_en = 1'b1; lat = 1;
        repeat (8) step();
        chk("s2_ngrants", 32'(g_log.size()), 32'd4);
        chk("s2_last",    qget(g_log, 3),    32'h6);
        chk("s2_req_off", 32'(s_req),        32'h0);
        chk("s2_full",    32'(s_valid),      32'h1);
        ready_v = 1'b1;
        repeat (14) step();
        chk("s2_resume", qget(g_log, 4), 32'h8);
        for (int i = 0; i < 6; i++) chk("s2_order", qget(c_pc, i), 32'(2 * i));

        // redirect with two grants outstanding
        do_reset();
        gnt_v = 1'b1; ready_v = 1'b1; rsp_en = 1'b0; lat = 1;
        redir_v = 1'b1; redir_pc_v = 32'h10;
        step();
        redir_v = 1'b0;
        repeat (3) step();
        chk("s3_g0", qget(g_log, 0), 32'h10);
        chk("s3_g1", qget(g_log, 1), 32'h12);
        gnt_v = 1'b0; redir_v = 1'b1; redir_pc_v = 32'h41;
        step();
        redir_v = 1'b0;
        step();
        chk("s3_flushing", 32'(s_flush), 32'h1);
        chk("s3_noreq",    32'(s_req),   32'h0);
        rsp_en = 1'b1; gnt_v = 1'b1;
        repeat (10) step();
        chk("s3_newaddr", qget(g_log, 2), 32'h40);
        chk("s3_pc0",     qget(c_pc, 0),  32'h40);
        chk("s3_ir0",     qget(c_ir, 0),  32'h7C7D);

        // redirect coincident with a response and a pop
        do_reset();
        gnt_v = 1'b1; ready_v = 1'b0; rsp_en = 1'b0; lat = 1;
        step();
        step();
        rsp_en = 1'b1;
        step();
        rsp_en = 1'b0;
        step();
        rsp_en = 1'b1; ready_v = 1'b1; redir_v = 1'b1; redir_pc_v = 32'h80;
        step();
        redir_v = 1'b0; rsp_en = 1'b0;
        step();
        chk("s4_empty",    32'(s_valid), 32'h0);
        chk("s4_flushing", 32'(s_flush), 32'h1);
        rsp_en = 1'b1;
        repeat (8) step();
        chk("s4_pop",  qget(c_pc, 0),  32'h0);
        chk("s4_next", qget(c_pc, 1),  32'h80);
        chk("s4_g2",   qget(g_log, 2), 32'h4);
        chk("s4_g3",   qget(g_log, 3), 32'h80);

        // PC wrap at top of address space; bit 0 of target ignored
        do_reset();
        gnt_v = 1'b1; ready_v = 1'b1; rsp_en = 1'b1; lat = 1;
        redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFFD;
        step();
        redir_v = 1'b0;
        repeat (6) step();
        chk("s5_g0",  qget(g_log, 0), 32'hFFFF_FFFC);
        chk("s5_g1",  qget(g_log, 1), 32'hFFFF_FFFE);
        chk("s5_g2",  qget(g_log, 2), 32'h0);
        chk("s5_pc1", qget(c_pc, 1),  32'hFFFF_FFFE);
        chk("s5_ir1", qget(c_ir, 1),  32'h3D3C);

        // stray response with nothing outstanding
        do_reset();
        gnt_v = 1'b0; spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        chk("s6_stray", 32'(s_valid), 32'h0);
        gnt_v = 1'b1; ready_v = 1'b1; rsp_en = 1'b1;
        repeat (5) step();
        chk("s6_pc0", qget(c_pc, 0), 32'h0);

        // asynchronous reset mid-burst
        do_reset();
        gnt_v = 1'b1; ready_v = 1'b1; rsp_en = 1'b1; lat = 1;
        repeat (5) step();
        async_reset();
        step();
        rst_v = 1'b0;
        clear_logs();
        repeat (4) step();
        chk("s7_g0", qget(g_log, 0), 32'h0);
        chk("s7_g1", qget(g_log, 1), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
